prio_event_arbiter: RTL and testbench
=====================================

# prio_event_arbiter

Parametrised, registered successor to the combinational 16-input priority encoder. Captures request events on `N` lines into a pending register and selects a winner by fixed (highest index) or round-robin priority. Presents the winner's index through a valid/ready output register, so no event is lost under back-pressure. Sits between raw request/status lines and any downstream consumer of "which line fired" codes.

## Interface
- `N`, 16: number of request lines, 2..64.
- `IDXW`, $clog2(N): index width.
- `clk` in 1: clock; all registers on rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: clock enable; low = every register holds and handshakes are ignored.
- `req_in` in N: request lines, synchronous to `clk`.
- `edge_mode` in 1: 0 = level mode, 1 = rising-edge event capture.
- `rr_mode` in 1: 0 = fixed priority (highest index wins), 1 = round robin.
- `out_ready` in 1: consumer accepts `out_idx` when high with `out_valid`.
- `ovf_clr` in 1: synchronous clear of `ovf`.
- `out_valid` out 1: `out_idx` holds a presented winner.
- `out_idx` out IDXW: winning line index.
- `out_count` out IDXW+1: popcount of the pending register.
- `ovf` out 1: sticky flag, set when an event is lost.

## Operation
- Registers: `req_q[N]`, `pending[N]`, `ptr[IDXW]`, `out_valid`, `out_idx`, `ovf`. All reset to 0 asynchronously.
- `rise = req_in & ~req_q`. `req_q <= req_in` each enabled edge.
- `pop = out_valid & out_ready & ena`. `load = ena & (~out_valid | pop) & (cand != 0)`.
- Candidate set `cand`:
  - Edge mode: `cand = pending`.
  - Level mode: `cand = pending`, where `pending <= req_in` each enabled edge.
- Selection:
  - Fixed priority: highest set index of `cand`.
  - Round robin: search descending from `ptr-1`, wrapping through `N-1` down to `ptr`. The last granted line therefore has lowest priority. With `ptr=0`, the order is N-1..0, identical to fixed priority.
- On `load`: `out_idx <= winner`, `out_valid <= 1`, `ptr <= winner`.
  - `ptr` updates in fixed mode too.
  - In edge mode, `pending[winner]` clears at the same edge unless `rise[winner]` is also set that edge. A new event wins over the clear.
- On `pop` without `load`: `out_valid <= 0`. `out_idx` holds its last value.
- While `out_valid & ~out_ready`: `out_idx` and `out_valid` are frozen. A new higher-priority request never pre-empts the presented index.
- Edge-mode pending update: `pending <= (pending & ~clr) | rise`, where `clr` is the one-hot of the loaded winner.
- `ovf` sets when `rise[i]` occurs on a bit with `pending[i]=1` that is not cleared that edge.
  - Set takes priority over `ovf_clr` in the same cycle.
  - `ovf` stays 0 in level mode.
- Mode bits are sampled every edge. After a switch, the new rule applies from the next edge onward, and `pending` is not flushed.
  - Level to edge switch: `pending` keeps its last level snapshot, and those bits are treated as events.
- Edge mode after reset: `req_q=0`, so lines already high at reset release count as rises on the first enabled edge.
- `ena` low: `req_q` is not updated. A rise that occurs while `ena` is low and stays high is captured on the first enabled edge.
- `out_count` is combinational popcount of the `pending` register.

## Timing
- Latency: `req_in` first high at edge E0 → `pending` set after E0 → `out_valid=1`, `out_idx` valid after E1. Total 2 cycles in both modes.
- Throughput: one index per cycle with `out_ready` held high. Back-to-back loads occur on the pop edge, so there is no bubble.
- Reset values: `out_valid=0`, `out_idx=0`, `out_count=0`, `ovf=0`. Values are forced immediately on `rst_n` falling, independent of `clk`.
- Reset mid-transfer drops the presented index and all pending events.
- Empty `cand`: no load; `out_valid` falls on the pop edge.
- Full `pending`: further rises only set `ovf`.

## Test plan
- Fixed, edge mode, N=16, `out_ready=1`: one-cycle pulse on bits 3 and 12 together → `out_idx`=12 then 3 on consecutive cycles; `out_count` 2→1→0; `out_valid` low on the third cycle.
- Back-pressure: pulse bit 5 with `out_ready=0` → `out_idx`=5 with `out_valid=1` stable for 10 cycles. Pulse bit 9 during the hold → `out_idx` stays 5. Raise `out_ready` → 5 accepted, then 9 next cycle, then `out_valid=0`.
- Round robin, level mode: hold bits 0, 7 and 15 high, `out_ready=1` → `out_idx` sequence 15, 7, 0, 15, 7, 0. With `rr_mode=0` and the same stimulus → 15 every cycle.
- Overflow: edge mode, `out_ready=0`, `out_idx`=2 presented. Pulse bit 4 twice → `ovf=1` and `out_count`=1. Pulse `ovf_clr` → `ovf=0`.
- Async reset: `out_valid=1`, pending=0x0F0F. Drop `rst_n` mid-cycle → `out_valid`, `out_idx`, `out_count`, `ovf` all 0 before the next `clk` edge. After release with bit 6 held high in edge mode → `out_idx`=6 two cycles later.
- `ena` low for 5 cycles with `out_valid=1`, `out_ready=1` and new pulses → no pop and all outputs frozen. With `ena` high again, a line still high is captured and presented 2 cycles later.

Source files
------------

// File: rtl/prio_event_arbiter.sv
// -----------------------------------------------------------------------------
// prio_event_arbiter
//
// Registered priority arbiter for N request lines. Requests are captured into a
// pending register, either as level snapshots (edge_mode=0) or as rising-edge
// events (edge_mode=1). A winner is picked from the pending set, by highest
// index (rr_mode=0) or round robin starting just below the last grant
// (rr_mode=1). The winner's index is offered through a valid/ready output
// register. Events that arrive on a bit that is still pending are counted as
// lost and raise the sticky ovf flag.
//
// Ports
//   clk        in   clock, all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   ena        in   clock enable; low freezes all state and ignores handshakes
//   req_in     in   [N-1:0] request lines, synchronous to clk
//   edge_mode  in   0 = level capture, 1 = rising-edge event capture
//   rr_mode    in   0 = fixed priority (highest index), 1 = round robin
//   out_ready  in   consumer accepts out_idx while out_valid is high
//   ovf_clr    in   synchronous clear of ovf (a same-cycle set wins)
//   out_valid  out  out_idx holds a presented winner
//   out_idx    out  [IDXW-1:0] winning line index
//   out_count  out  [IDXW:0] number of set bits in the pending register
//   ovf        out  sticky lost-event flag
// -----------------------------------------------------------------------------
module prio_event_arbiter #(
    parameter int N    = 16,
    parameter int IDXW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ena,
    input  logic [N-1:0]    req_in,
    input  logic            edge_mode,
    input  logic            rr_mode,
    input  logic            out_ready,
    input  logic            ovf_clr,
    output logic            out_valid,
    output logic [IDXW-1:0] out_idx,
    output logic [IDXW:0]   out_count,
    output logic            ovf
);

    logic [N-1:0]    req_q;
    logic [N-1:0]    pending;
    logic [IDXW-1:0] ptr;

    logic [N-1:0]    rise;
    logic [N-1:0]    cand;
    logic [N-1:0]    clr;
    logic [N-1:0]    pending_next;
    logic            pop;
    logic            load;
    logic            lost;
    logic [IDXW-1:0] fix_idx;
    logic [IDXW-1:0] rr_idx;
    logic [IDXW-1:0] winner;

    assign rise = req_in & ~req_q;
    assign cand = pending;
    assign pop  = out_valid & out_ready & ena;
    // A new winner is taken whenever the output slot is empty or being
    // emptied this edge, which gives back-to-back loads without a bubble.
    assign load = ena & (~out_valid | pop) & (|cand);

    // Fixed priority: the last set bit seen while scanning upward wins.
    always_comb begin
        fix_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                fix_idx = IDXW'(i);
            end
        end
    end

    // Round robin: priority order is ptr-1, ptr-2, ..., wrapping to N-1, ...,
    // ptr. Scanning from the lowest-priority offset upward and overwriting
    // leaves the highest-priority set bit in rr_idx.
    always_comb begin : rr_search
        int pos;
        rr_idx = '0;
        pos    = 0;
        for (int k = N; k >= 1; k--) begin
            pos = int'(ptr) + N - k;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (cand[pos]) begin
                rr_idx = IDXW'(pos);
            end
        end
    end

    assign winner = rr_mode ? rr_idx : fix_idx;

    // One-hot of the granted line; only meaningful when a load happens.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_clr
            assign clr[gi] = load & (winner == IDXW'(gi));
        end
    endgenerate

    // Edge mode: a fresh rise on the granted bit re-arms it instead of
    // letting the grant clear it, so that event is not lost.
    always_comb begin
        if (edge_mode) begin
            pending_next = (pending & ~clr) | rise;
        end else begin
            pending_next = req_in;
        end
    end

    // An event is lost when it lands on a bit that is still pending and is
    // not being granted at this edge. Level mode never loses events.
    assign lost = edge_mode & (|(rise & pending & ~clr));

    always_comb begin
        out_count = '0;
        for (int i = 0; i < N; i++) begin
            out_count = out_count + (IDXW + 1)'(pending[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q     <= '0;
            pending   <= '0;
            ptr       <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ovf       <= 1'b0;
        end else if (ena) begin
            req_q   <= req_in;
            pending <= pending_next;
            if (load) begin
                out_idx   <= winner;
                out_valid <= 1'b1;
                ptr       <= winner;
            end else if (pop) begin
                // out_idx keeps its last value after the slot empties.
                out_valid <= 1'b0;
            end
            if (lost) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prio_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_prio_event_arbiter
//
// Directed bench for prio_event_arbiter with N=16. Inputs are driven 1 ns
// after a rising edge and outputs are sampled at the same point, so every
// check shows the state that the preceding edge produced.
// -----------------------------------------------------------------------------
module tb_prio_event_arbiter;

    localparam int N    = 16;
    localparam int IDXW = 4;

    logic            clk;
    logic            rst_n;
    logic            ena;
    logic [N-1:0]    req_in;
    logic            edge_mode;
    logic            rr_mode;
    logic            out_ready;
    logic            ovf_clr;
    logic            out_valid;
    logic [IDXW-1:0] out_idx;
    logic [IDXW:0]   out_count;
    logic            ovf;

    int n_cmp;
    int n_err;

    prio_event_arbiter #(.N(N), .IDXW(IDXW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .req_in    (req_in),
        .edge_mode (edge_mode),
        .rr_mode   (rr_mode),
        .out_ready (out_ready),
        .ovf_clr   (ovf_clr),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .out_count (out_count),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs,
                             input logic [63:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, expv);
        end else begin
            $display("ok   %s: %0d", tag, obs);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        ena       = 1'b1;
        req_in    = '0;
        out_ready = 1'b0;
        ovf_clr   = 1'b0;
        step(2);
        rst_n = 1'b1;
    endtask

    initial begin : stim
        int rr_seq[6];
        n_cmp = 0;
        n_err = 0;
        edge_mode = 1'b1;
        rr_mode   = 1'b0;

        // ---------------- reset values ----------------
        do_reset();
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_idx",   64'(out_idx),   64'd0);
        check_val("rst_count", 64'(out_count), 64'd0);
        check_val("rst_ovf",   64'(ovf),       64'd0);

        // ---------------- fixed, edge, bits 3 and 12 ----------------
        out_ready = 1'b1;
        req_in    = 16'h1008;
        step(1);
        req_in = '0;
        check_val("fx_count0", 64'(out_count), 64'd2);
        check_val("fx_valid0", 64'(out_valid), 64'd0);
        step(1);
        check_val("fx_idx1",   64'(out_idx),   64'd12);
        check_val("fx_valid1", 64'(out_valid), 64'd1);
        check_val("fx_count1", 64'(out_count), 64'd1);
        step(1);
        check_val("fx_idx2",   64'(out_idx),   64'd3);
        check_val("fx_count2", 64'(out_count), 64'd0);
        step(1);
        check_val("fx_valid3", 64'(out_valid), 64'd0);

        // ---------------- back-pressure ----------------
        do_reset();
        edge_mode = 1'b1;
        rr_mode   = 1'b0;
        req_in    = 16'h0020;
        step(1);
        req_in = '0;
        step(1);
        for (int c = 0; c < 10; c++) begin
            if (c == 3) req_in = 16'h0200;
            if (c == 4) req_in = '0;
            check_val($sformatf("bp_hold_valid%0d", c), 64'(out_valid), 64'd1);
            check_val($sformatf("bp_hold_idx%0d", c),   64'(out_idx),   64'd5);
            step(1);
        end
        check_val("bp_count_hold", 64'(out_count), 64'd1);
        out_ready = 1'b1;
        step(1);
        check_val("bp_idx9",   64'(out_idx),   64'd9);
        check_val("bp_valid9", 64'(out_valid), 64'd1);
        step(1);
        check_val("bp_valid_end", 64'(out_valid), 64'd0);

        // ---------------- round robin, level mode ----------------
        do_reset();
        edge_mode = 1'b0;
        rr_mode   = 1'b1;
        out_ready = 1'b1;
        req_in    = 16'h8081;
        rr_seq    = '{15, 7, 0, 15, 7, 0};
        step(1);
        check_val("rr_count", 64'(out_count), 64'd3);
        for (int c = 0; c < 6; c++) begin
            step(1);
            check_val($sformatf("rr_idx%0d", c), 64'(out_idx), 64'(rr_seq[c]));
        end
        rr_mode = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            check_val($sformatf("lvl_fixed_idx%0d", c), 64'(out_idx), 64'd15);
        end
        check_val("lvl_ovf", 64'(ovf), 64'd0);
        req_in = '0;

        // ---------------- overflow ----------------
        do_reset();
        edge_mode = 1'b1;
        rr_mode   = 1'b0;
        req_in    = 16'h0004;
        step(1);
        req_in = '0;
        step(1);
        check_val("ov_idx2", 64'(out_idx), 64'd2);
        req_in = 16'h0010;
        step(1);
        req_in = '0;
        step(1);
        check_val("ov_count_a", 64'(out_count), 64'd1);
        check_val("ov_ovf_a",   64'(ovf),       64'd0);
        req_in = 16'h0010;
        step(1);
        req_in = '0;
        check_val("ov_ovf_set", 64'(ovf),       64'd1);
        check_val("ov_count_b", 64'(out_count), 64'd1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        check_val("ov_ovf_clr", 64'(ovf), 64'd0);
        req_in  = 16'h0010;
        ovf_clr = 1'b1;
        step(1);
        req_in  = '0;
        ovf_clr = 1'b0;
        check_val("ov_set_wins", 64'(ovf), 64'd1);

        // ---------------- asynchronous reset ----------------
        do_reset();
        edge_mode = 1'b1;
        rr_mode   = 1'b0;
        req_in    = 16'h8F0F;
        step(1);
        req_in = '0;
        step(1);
        check_val("ar_idx15", 64'(out_idx),   64'd15);
        check_val("ar_count", 64'(out_count), 64'd8);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("ar_valid0", 64'(out_valid), 64'd0);
        check_val("ar_idx0",   64'(out_idx),   64'd0);
        check_val("ar_count0", 64'(out_count), 64'd0);
        check_val("ar_ovf0",   64'(ovf),       64'd0);
        req_in = 16'h0040;
        step(2);
        rst_n = 1'b1;
        step(1);
        check_val("ar_rel_valid", 64'(out_valid), 64'd0);
        step(1);
        check_val("ar_rel_idx6",   64'(out_idx),   64'd6);
        check_val("ar_rel_valid6", 64'(out_valid), 64'd1);
        req_in = '0;

        // ---------------- clock enable ----------------
        do_reset();
        edge_mode = 1'b1;
        rr_mode   = 1'b0;
        req_in    = 16'h0020;
        step(1);
        req_in = '0;
        step(1);
        ena       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (c == 0) req_in = 16'h0402;
            if (c == 1) req_in = 16'h0400;
            step(1);
            check_val($sformatf("en_valid%0d", c), 64'(out_valid), 64'd1);
            check_val($sformatf("en_idx%0d", c),   64'(out_idx),   64'd5);
            check_val($sformatf("en_count%0d", c), 64'(out_count), 64'd0);
        end
        ena = 1'b1;
        step(1);
        check_val("en_pop_valid", 64'(out_valid), 64'd0);
        check_val("en_cap_count", 64'(out_count), 64'd1);
        step(1);
        check_val("en_idx10",   64'(out_idx),   64'd10);
        check_val("en_valid10", 64'(out_valid), 64'd1);
        step(1);
        check_val("en_end_valid", 64'(out_valid), 64'd0);
        req_in = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
